// File: rtl/mem_arbiter.sv
`timescale 1ns/1ps
// mem_arbiter
//   Arbitrates the cpu16 instruction-fetch port, the cpu16 data port and the
//   SPI debug write strobe onto the single-read/single-write SRAM port and the
//   shared system write bus (SRAM/VRAM/CTRL). Requests may be stalled.
//   Reads are granted combinationally, and the SRAM returns data one cycle
//   later. The write bus is granted combinationally as well.
//
// Parameters
//   RR_READ     1 = round-robin between ins and dat reads on contention,
//               0 = ins has fixed priority
//   RD_FILL     word returned for dat reads outside the SRAM region
//
// Ports
//   clk, reset_n                         system clock, async active-low reset
//   ins_rd_addr/req -> ins_rd_rdy/data   instruction fetch (rdy = 1-cycle pulse)
//   dat_rw_addr, dat_rd_req              data read  -> dat_rd_rdy/dat_rd_data
//   dat_wr_req, dat_wr_data              data write -> dat_wr_rdy
//   dbg_we, dbg_waddr, dbg_wdata         debug write strobe, never stalled
//   mem_raddr, mem_re, mem_rdata         SRAM read port (rdata registered)
//   sys_waddr, sys_wdata, sys_we         system write bus
module mem_arbiter #(
  parameter bit          RR_READ = 1'b1,
  parameter logic [15:0] RD_FILL = 16'hEEEE
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] ins_rd_addr,
  input  logic        ins_rd_req,
  output logic        ins_rd_rdy,
  output logic [15:0] ins_rd_data,
  input  logic [15:0] dat_rw_addr,
  input  logic        dat_rd_req,
  output logic        dat_rd_rdy,
  output logic [15:0] dat_rd_data,
  input  logic        dat_wr_req,
  input  logic [15:0] dat_wr_data,
  output logic        dat_wr_rdy,
  input  logic        dbg_we,
  input  logic [15:0] dbg_waddr,
  input  logic [15:0] dbg_wdata,
  output logic [15:0] mem_raddr,
  output logic        mem_re,
  input  logic [15:0] mem_rdata,
  output logic [15:0] sys_waddr,
  output logic [15:0] sys_wdata,
  output logic        sys_we
);

  logic        dat_sram_p0;
  logic        dat_fill_p0;
  logic        contend_p0;
  logic        dat_wins_p0;
  logic        ins_grant_p0;
  logic        dat_grant_p0;
  logic        wr_grant_p0;
  logic [15:0] raddr_p0;

  logic        vld_ins_p1;
  logic        vld_dat_p1;
  logic        vld_fill_p1;
  logic        vld_wr_p1;
  logic        ins_lost_p1;
  logic        dat_lost_p1;
  logic        rr_dat_q;

  logic [15:0] raddr_hold_q;
  logic [15:0] ins_hold_q;
  logic [15:0] dat_hold_q;

  // ---- stage p0: request decode and grant ----
  always_comb begin
    dat_sram_p0 = dat_rd_req && (dat_rw_addr[15:12] == 4'h0);
    dat_fill_p0 = dat_rd_req && !dat_sram_p0;
    contend_p0  = ins_rd_req && dat_sram_p0;

    // A side that lost the previous contention wins outright, which bounds
    // the wait to one cycle even under fixed priority.
    if (dat_lost_p1) begin
      dat_wins_p0 = 1'b1;
    end else if (ins_lost_p1) begin
      dat_wins_p0 = 1'b0;
    end else begin
      dat_wins_p0 = RR_READ && rr_dat_q;
    end

    ins_grant_p0 = ins_rd_req  && !(contend_p0 &&  dat_wins_p0);
    dat_grant_p0 = dat_sram_p0 && !(contend_p0 && !dat_wins_p0);

    if (ins_grant_p0) begin
      raddr_p0 = ins_rd_addr;
    end else if (dat_grant_p0) begin
      raddr_p0 = dat_rw_addr;
    end else begin
      raddr_p0 = raddr_hold_q;
    end

    // The debug strobe always owns the bus; a cpu write also yields to a
    // pending cpu read and to its own rdy cycle (forced 1-cycle gap).
    wr_grant_p0 = dat_wr_req && !dat_rd_req && !dbg_we && !vld_wr_p1;
  end

  // Combinational outputs read zero while reset is asserted.
  assign mem_re    = reset_n && (ins_grant_p0 || dat_grant_p0);
  assign mem_raddr = reset_n ? raddr_p0 : 16'h0000;
  assign sys_we    = reset_n && (dbg_we || wr_grant_p0);
  assign sys_waddr = !reset_n ? 16'h0000 : (dbg_we ? dbg_waddr : dat_rw_addr);
  assign sys_wdata = !reset_n ? 16'h0000 : (dbg_we ? dbg_wdata : dat_wr_data);

  // ---- stage p1: grant results, arbitration history ----
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_ins_p1  <= 1'b0;
      vld_dat_p1  <= 1'b0;
      vld_fill_p1 <= 1'b0;
      vld_wr_p1   <= 1'b0;
      ins_lost_p1 <= 1'b0;
      dat_lost_p1 <= 1'b0;
      rr_dat_q    <= 1'b0;
    end else begin
      vld_ins_p1  <= ins_grant_p0;
      vld_dat_p1  <= dat_grant_p0;
      vld_fill_p1 <= dat_fill_p0;
      vld_wr_p1   <= wr_grant_p0;
      ins_lost_p1 <= contend_p0 &&  dat_wins_p0;
      dat_lost_p1 <= contend_p0 && !dat_wins_p0;
      if (RR_READ && contend_p0) begin
        rr_dat_q <= !dat_wins_p0;
      end
    end
  end

  // Data holding registers are cleared too so every output reads zero
  // out of reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      raddr_hold_q <= 16'h0000;
      ins_hold_q   <= 16'h0000;
      dat_hold_q   <= 16'h0000;
    end else begin
      if (ins_grant_p0 || dat_grant_p0) begin
        raddr_hold_q <= raddr_p0;
      end
      if (vld_ins_p1) begin
        ins_hold_q <= mem_rdata;
      end
      if (vld_dat_p1 || vld_fill_p1) begin
        dat_hold_q <= dat_rd_data;
      end
    end
  end

  assign ins_rd_rdy  = vld_ins_p1;
  assign dat_rd_rdy  = vld_dat_p1 || vld_fill_p1;
  assign dat_wr_rdy  = vld_wr_p1;
  assign ins_rd_data = vld_ins_p1 ? mem_rdata : ins_hold_q;
  assign dat_rd_data = vld_dat_p1  ? mem_rdata :
                       vld_fill_p1 ? RD_FILL   : dat_hold_q;

endmodule

// File: tb/tb_mem_arbiter.sv
`timescale 1ns/1ps
module tb_mem_arbiter;
  localparam bit          RR   = 1'b1;
  localparam logic [15:0] FILL = 16'hEEEE;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [15:0] ins_rd_addr;
  logic        ins_rd_req;
  logic        ins_rd_rdy;
  logic [15:0] ins_rd_data;
  logic [15:0] dat_rw_addr;
  logic        dat_rd_req;
  logic        dat_rd_rdy;
  logic [15:0] dat_rd_data;
  logic        dat_wr_req;
  logic [15:0] dat_wr_data;
  logic        dat_wr_rdy;
  logic        dbg_we;
  logic [15:0] dbg_waddr;
  logic [15:0] dbg_wdata;
  logic [15:0] mem_raddr;
  logic        mem_re;
  logic [15:0] mem_rdata;
  logic [15:0] sys_waddr;
  logic [15:0] sys_wdata;
  logic        sys_we;

  mem_arbiter #(.RR_READ(RR), .RD_FILL(FILL)) dut (
    .clk(clk), .reset_n(reset_n),
    .ins_rd_addr(ins_rd_addr), .ins_rd_req(ins_rd_req),
    .ins_rd_rdy(ins_rd_rdy), .ins_rd_data(ins_rd_data),
    .dat_rw_addr(dat_rw_addr), .dat_rd_req(dat_rd_req),
    .dat_rd_rdy(dat_rd_rdy), .dat_rd_data(dat_rd_data),
    .dat_wr_req(dat_wr_req), .dat_wr_data(dat_wr_data), .dat_wr_rdy(dat_wr_rdy),
    .dbg_we(dbg_we), .dbg_waddr(dbg_waddr), .dbg_wdata(dbg_wdata),
    .mem_raddr(mem_raddr), .mem_re(mem_re), .mem_rdata(mem_rdata),
    .sys_waddr(sys_waddr), .sys_wdata(sys_wdata), .sys_we(sys_we)
  );

  always #5 clk = ~clk;

  // SRAM with registered read port
  logic [15:0] sram [0:4095];
  always @(posedge clk) if (mem_re) mem_rdata <= sram[mem_raddr[11:0]];

  int n_vec = 0;
  int n_err = 0;

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chk16(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Transaction view: each cycle decide who is served; a read served now
  // answers next cycle with the SRAM word at its address (or the fill word).
  logic        m_ins_pend, m_dat_pend, m_dat_fill, m_wr_pend;
  logic [15:0] m_ins_addr, m_dat_addr, m_ins_hold, m_dat_hold, m_last_raddr;
  logic        m_dat_next;     // side to favour at the next contention (1 = dat)
  int          m_waiting;      // 0 none, 1 ins lost last contention, 2 dat lost
  logic        e_we, e_gi, e_gd, e_dsram, e_dfill, e_wr_acc;
  logic [15:0] e_wa, e_wd, e_ra;

  always @(negedge clk) begin
    if (!reset_n) begin
      chk1 ("rst ins_rd_rdy", ins_rd_rdy, 1'b0);
      chk1 ("rst dat_rd_rdy", dat_rd_rdy, 1'b0);
      chk1 ("rst dat_wr_rdy", dat_wr_rdy, 1'b0);
      chk1 ("rst mem_re", mem_re, 1'b0);
      chk1 ("rst sys_we", sys_we, 1'b0);
      chk16("rst mem_raddr", mem_raddr, 16'h0000);
      chk16("rst ins_rd_data", ins_rd_data, 16'h0000);
      chk16("rst dat_rd_data", dat_rd_data, 16'h0000);
      m_ins_pend = 0; m_dat_pend = 0; m_dat_fill = 0; m_wr_pend = 0;
      m_ins_addr = 0; m_dat_addr = 0; m_ins_hold = 0; m_dat_hold = 0;
      m_last_raddr = 0; m_dat_next = 0; m_waiting = 0;
    end else begin
      // answers to last cycle's grants
      if (m_ins_pend) m_ins_hold = sram[m_ins_addr[11:0]];
      if (m_dat_pend) m_dat_hold = m_dat_fill ? FILL : sram[m_dat_addr[11:0]];
      chk1 ("ins_rd_rdy", ins_rd_rdy, m_ins_pend);
      chk16("ins_rd_data", ins_rd_data, m_ins_hold);
      chk1 ("dat_rd_rdy", dat_rd_rdy, m_dat_pend);
      chk16("dat_rd_data", dat_rd_data, m_dat_hold);
      chk1 ("dat_wr_rdy", dat_wr_rdy, m_wr_pend);

      // write bus
      e_wr_acc = 1'b0;
      if (dbg_we) begin
        e_we = 1'b1; e_wa = dbg_waddr; e_wd = dbg_wdata;
      end else if (dat_wr_req && !dat_rd_req && !m_wr_pend) begin
        e_we = 1'b1; e_wa = dat_rw_addr; e_wd = dat_wr_data; e_wr_acc = 1'b1;
      end else begin
        e_we = 1'b0; e_wa = 16'h0; e_wd = 16'h0;
      end
      chk1("sys_we", sys_we, e_we);
      if (e_we) begin
        chk16("sys_waddr", sys_waddr, e_wa);
        chk16("sys_wdata", sys_wdata, e_wd);
      end

      // read port
      e_dsram = dat_rd_req && (dat_rw_addr[15:12] == 4'h0);
      e_dfill = dat_rd_req && !e_dsram;
      e_gi = ins_rd_req;
      e_gd = e_dsram;
      if (ins_rd_req && e_dsram) begin
        if (m_waiting == 2)      e_gi = 1'b0;
        else if (m_waiting == 1) e_gd = 1'b0;
        else if (RR && m_dat_next) e_gi = 1'b0;
        else                     e_gd = 1'b0;
        if (RR) m_dat_next = e_gi;
        m_waiting = e_gi ? 2 : 1;
      end else begin
        m_waiting = 0;
      end
      e_ra = e_gi ? ins_rd_addr : (e_gd ? dat_rw_addr : m_last_raddr);
      chk1 ("mem_re", mem_re, e_gi | e_gd);
      chk16("mem_raddr", mem_raddr, e_ra);
      m_last_raddr = e_ra;
      m_ins_pend = e_gi;  m_ins_addr = ins_rd_addr;
      m_dat_pend = e_gd | e_dfill; m_dat_fill = e_dfill; m_dat_addr = dat_rw_addr;
      m_wr_pend  = e_wr_acc;
    end
  end

  // ---------------- stimulus ----------------
  task automatic idle_in();
    ins_rd_req = 0; dat_rd_req = 0; dat_wr_req = 0; dbg_we = 0;
  endtask

  task automatic edge_drive();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    edge_drive(); reset_n = 0; idle_in();
    edge_drive(); reset_n = 1;
  endtask

  logic ri, rd, rw;
  int   op;

  initial begin
    reset_n = 0;
    ins_rd_addr = 0; dat_rw_addr = 0; dat_wr_data = 0;
    dbg_waddr = 0; dbg_wdata = 0; mem_rdata = 0;
    idle_in();
    for (int i = 0; i < 4096; i++) sram[i] = 16'($urandom);
    sram[16'h0010] = 16'h1234;
    sram[16'h0020] = 16'hCAFE;
    repeat (3) @(posedge clk);

    // reset held with all requests high
    #1;
    ins_rd_req = 1; ins_rd_addr = 16'h0010;
    dat_rd_req = 1; dat_wr_req = 1; dat_rw_addr = 16'h0020; dat_wr_data = 16'h1111;
    @(negedge clk);
    chk1("d_rst_ins_rdy", ins_rd_rdy, 1'b0);
    chk1("d_rst_mem_re", mem_re, 1'b0);
    chk1("d_rst_sys_we", sys_we, 1'b0);
    edge_drive(); reset_n = 1;
    @(negedge clk);
    chk1 ("d_rel_mem_re", mem_re, 1'b1);
    chk16("d_rel_raddr", mem_raddr, 16'h0010);
    chk1 ("d_rel_sys_we", sys_we, 1'b0);
    edge_drive(); idle_in();
    @(negedge clk);
    chk1("d_rel_ins_rdy", ins_rd_rdy, 1'b1);
    do_reset();

    // instruction fetch, held request -> one per cycle
    edge_drive(); ins_rd_req = 1; ins_rd_addr = 16'h0010;
    @(negedge clk);
    chk1 ("d_f_re", mem_re, 1'b1);
    chk16("d_f_raddr", mem_raddr, 16'h0010);
    edge_drive();
    @(negedge clk);
    chk1 ("d_f_rdy1", ins_rd_rdy, 1'b1);
    chk16("d_f_data1", ins_rd_data, 16'h1234);
    chk1 ("d_f_re2", mem_re, 1'b1);
    edge_drive(); ins_rd_req = 0;
    @(negedge clk);
    chk1 ("d_f_rdy2", ins_rd_rdy, 1'b1);
    chk1 ("d_f_re3", mem_re, 1'b0);
    chk16("d_f_raddr_hold", mem_raddr, 16'h0010);
    edge_drive();
    @(negedge clk);
    chk1 ("d_f_rdy3", ins_rd_rdy, 1'b0);
    chk16("d_f_data_hold", ins_rd_data, 16'h1234);
    do_reset();

    // contention, round robin
    edge_drive(); ins_rd_req = 1; ins_rd_addr = 16'h0010; dat_rd_req = 1; dat_rw_addr = 16'h0020;
    @(negedge clk);
    chk16("d_c_raddr1", mem_raddr, 16'h0010);
    edge_drive(); ins_rd_req = 0;
    @(negedge clk);
    chk1 ("d_c_ins_rdy", ins_rd_rdy, 1'b1);
    chk16("d_c_ins_data", ins_rd_data, 16'h1234);
    chk16("d_c_raddr2", mem_raddr, 16'h0020);
    edge_drive(); dat_rd_req = 0;
    @(negedge clk);
    chk1 ("d_c_dat_rdy", dat_rd_rdy, 1'b1);
    chk16("d_c_dat_data", dat_rd_data, 16'hCAFE);
    edge_drive(); ins_rd_req = 1; dat_rd_req = 1;
    @(negedge clk);
    chk16("d_c_raddr3_dat_first", mem_raddr, 16'h0020);
    edge_drive(); dat_rd_req = 0;
    @(negedge clk);
    chk1 ("d_c_dat_rdy2", dat_rd_rdy, 1'b1);
    chk16("d_c_raddr4", mem_raddr, 16'h0010);
    edge_drive(); ins_rd_req = 0;
    @(negedge clk);
    chk1("d_c_ins_rdy2", ins_rd_rdy, 1'b1);

    // bypass read alongside a fetch
    edge_drive(); ins_rd_req = 1; ins_rd_addr = 16'h0010; dat_rd_req = 1; dat_rw_addr = 16'h8005;
    @(negedge clk);
    chk16("d_b_raddr", mem_raddr, 16'h0010);
    edge_drive(); idle_in();
    @(negedge clk);
    chk1 ("d_b_dat_rdy", dat_rd_rdy, 1'b1);
    chk16("d_b_dat_data", dat_rd_data, 16'hEEEE);
    chk1 ("d_b_ins_rdy", ins_rd_rdy, 1'b1);

    // debug strobe against a cpu write
    edge_drive();
    dbg_we = 1; dbg_waddr = 16'h8001; dbg_wdata = 16'h0041;
    dat_wr_req = 1; dat_rw_addr = 16'h0002; dat_wr_data = 16'hBEEF;
    @(negedge clk);
    chk16("d_w_addr0", sys_waddr, 16'h8001);
    chk16("d_w_data0", sys_wdata, 16'h0041);
    chk1 ("d_w_rdy0", dat_wr_rdy, 1'b0);
    edge_drive(); dbg_we = 0;
    @(negedge clk);
    chk1 ("d_w_we1", sys_we, 1'b1);
    chk16("d_w_addr1", sys_waddr, 16'h0002);
    chk16("d_w_data1", sys_wdata, 16'hBEEF);
    edge_drive(); dat_wr_req = 0;
    @(negedge clk);
    chk1("d_w_rdy2", dat_wr_rdy, 1'b1);
    chk1("d_w_we2", sys_we, 1'b0);

    // reset between grant and rdy
    edge_drive(); ins_rd_req = 1; ins_rd_addr = 16'h0010;
    @(negedge clk);
    chk1("d_x_re", mem_re, 1'b1);
    #1 reset_n = 0;
    @(negedge clk);
    chk1("d_x_no_rdy", ins_rd_rdy, 1'b0);
    edge_drive(); reset_n = 1;
    @(negedge clk);
    chk1 ("d_x_re2", mem_re, 1'b1);
    chk16("d_x_raddr2", mem_raddr, 16'h0010);
    edge_drive(); ins_rd_req = 0;
    @(negedge clk);
    chk1 ("d_x_rdy", ins_rd_rdy, 1'b1);
    chk16("d_x_data", ins_rd_data, 16'h1234);
    edge_drive();
    @(negedge clk);
    chk1("d_x_rdy_once", ins_rd_rdy, 1'b0);

    // randomized traffic, protocol-respecting
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      ri = ins_rd_rdy; rd = dat_rd_rdy; rw = dat_wr_rdy;
      edge_drive();
      reset_n = ($urandom_range(0, 199) != 0);
      if (!ins_rd_req || ri) begin
        ins_rd_req  = ($urandom_range(0, 2) != 0);
        ins_rd_addr = 16'($urandom);
      end
      if (!(dat_rd_req || dat_wr_req) || (dat_rd_req && rd) || (dat_wr_req && rw)) begin
        op = int'($urandom_range(0, 2));
        dat_rd_req  = (op == 1);
        dat_wr_req  = (op == 2);
        if ($urandom_range(0, 1) == 0) dat_rw_addr = {4'h0, 12'($urandom)};
        else dat_rw_addr = {4'($urandom_range(1, 15)), 12'($urandom)};
        dat_wr_data = 16'($urandom);
      end
      dbg_we    = ($urandom_range(0, 3) == 0);
      dbg_waddr = 16'($urandom);
      dbg_wdata = 16'($urandom);
    end

    edge_drive(); reset_n = 1; idle_in();
    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
